// File: rtl/ray_aabb_slab_test.sv
// Ray versus axis-aligned box slab test, fully pipelined, one pair per cycle.
// Stage registers: S1 subtract, S2 multiply, S3 order, S4 reduce, then the output register.
module ray_aabb_slab_test #(
    parameter int              WIDTH  = 16,
    parameter int              Q_BITS = 12,
    parameter logic [WIDTH-1:0] MAX   = 16'h7FFF,
    parameter logic [WIDTH-1:0] MIN   = 16'h8000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic             skip_in,
    input  logic [WIDTH-1:0] inv_dir_x,
    input  logic [WIDTH-1:0] inv_dir_y,
    input  logic [WIDTH-1:0] inv_dir_z,
    input  logic [WIDTH-1:0] orig_x,
    input  logic [WIDTH-1:0] orig_y,
    input  logic [WIDTH-1:0] orig_z,
    input  logic [WIDTH-1:0] bmin_x,
    input  logic [WIDTH-1:0] bmin_y,
    input  logic [WIDTH-1:0] bmin_z,
    input  logic [WIDTH-1:0] bmax_x,
    input  logic [WIDTH-1:0] bmax_y,
    input  logic [WIDTH-1:0] bmax_z,
    output logic             valid_out,
    output logic             hit,
    output logic             skip_out,
    output logic [WIDTH-1:0] t_near,
    output logic [WIDTH-1:0] t_far
);

    function automatic logic [WIDTH-1:0] sat_diff(input logic signed [WIDTH:0] v);
        logic signed [WIDTH:0] hi;
        logic signed [WIDTH:0] lo;
        hi = {1'b0, MAX};
        lo = {1'b1, MIN};
        if (v > hi)      sat_diff = MAX;
        else if (v < lo) sat_diff = MIN;
        else             sat_diff = v[WIDTH-1:0];
    endfunction

    // Full-width signed product, floor shift back to Q format, then clamp.
    function automatic logic [WIDTH-1:0] mul_sat(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] ae;
        logic signed [2*WIDTH-1:0] be;
        logic signed [2*WIDTH-1:0] p;
        logic signed [2*WIDTH-1:0] sh;
        logic signed [2*WIDTH-1:0] hi;
        logic signed [2*WIDTH-1:0] lo;
        ae = {{WIDTH{a[WIDTH-1]}}, a};
        be = {{WIDTH{b[WIDTH-1]}}, b};
        p  = ae * be;
        sh = p >>> Q_BITS;
        hi = {{WIDTH{1'b0}}, MAX};
        lo = {{WIDTH{1'b1}}, MIN};
        if (sh > hi)      mul_sat = MAX;
        else if (sh < lo) mul_sat = MIN;
        else              mul_sat = sh[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] smax(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        smax = ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [WIDTH-1:0] smin(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        smin = ($signed(a) < $signed(b)) ? a : b;
    endfunction

    logic [WIDTH-1:0] inv_in  [3];
    logic [WIDTH-1:0] orig_in [3];
    logic [WIDTH-1:0] bmin_in [3];
    logic [WIDTH-1:0] bmax_in [3];

    assign inv_in  = '{inv_dir_x, inv_dir_y, inv_dir_z};
    assign orig_in = '{orig_x, orig_y, orig_z};
    assign bmin_in = '{bmin_x, bmin_y, bmin_z};
    assign bmax_in = '{bmax_x, bmax_y, bmax_z};

    logic [4:1] valid_q, valid_d;
    logic [4:1] skip_q,  skip_d;

    logic [WIDTH-1:0] d0_q [3], d0_d [3];
    logic [WIDTH-1:0] d1_q [3], d1_d [3];
    logic [WIDTH-1:0] inv_q [3];
    logic [WIDTH-1:0] t0_q [3], t0_d [3];
    logic [WIDTH-1:0] t1_q [3], t1_d [3];
    logic [WIDTH-1:0] near_q [3], near_d [3];
    logic [WIDTH-1:0] far_q [3], far_d [3];
    logic [WIDTH-1:0] tn4_q, tn4_d;
    logic [WIDTH-1:0] tf4_q, tf4_d;

    logic             valid_out_q, valid_out_d;
    logic             hit_q, hit_d;
    logic             skip_out_q, skip_out_d;
    logic [WIDTH-1:0] t_near_q, t_near_d;
    logic [WIDTH-1:0] t_far_q, t_far_d;

    always_comb begin
        valid_d = {valid_q[3:1], valid_in};
        skip_d  = {skip_q[3:1], skip_in};
        for (int a = 0; a < 3; a++) begin
            d0_d[a]   = sat_diff({bmin_in[a][WIDTH-1], bmin_in[a]} - {orig_in[a][WIDTH-1], orig_in[a]});
            d1_d[a]   = sat_diff({bmax_in[a][WIDTH-1], bmax_in[a]} - {orig_in[a][WIDTH-1], orig_in[a]});
            t0_d[a]   = mul_sat(d0_q[a], inv_q[a]);
            t1_d[a]   = mul_sat(d1_q[a], inv_q[a]);
            near_d[a] = smin(t0_q[a], t1_q[a]);
            far_d[a]  = smax(t0_q[a], t1_q[a]);
        end
        tn4_d = smax(smax(near_q[0], near_q[1]), near_q[2]);
        tf4_d = smin(smin(far_q[0], far_q[1]), far_q[2]);
    end

    // Outputs are zero whenever the output stage is empty.
    always_comb begin
        valid_out_d = valid_q[4];
        skip_out_d  = 1'b0;
        hit_d       = 1'b0;
        t_near_d    = '0;
        t_far_d     = '0;
        if (valid_q[4]) begin
            skip_out_d = skip_q[4];
            t_near_d   = tn4_q;
            t_far_d    = tf4_q;
            hit_d      = !skip_q[4] && ($signed(tn4_q) <= $signed(tf4_q)) && !tf4_q[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            skip_q  <= '0;
        end else begin
            valid_q <= valid_d;
            skip_q  <= skip_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int a = 0; a < 3; a++) begin
            if (valid_in) begin
                d0_q[a]  <= d0_d[a];
                d1_q[a]  <= d1_d[a];
                inv_q[a] <= inv_in[a];
            end
            if (valid_q[1]) begin
                t0_q[a] <= t0_d[a];
                t1_q[a] <= t1_d[a];
            end
            if (valid_q[2]) begin
                near_q[a] <= near_d[a];
                far_q[a]  <= far_d[a];
            end
        end
        if (valid_q[3]) begin
            tn4_q <= tn4_d;
            tf4_q <= tf4_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out_q <= 1'b0;
            hit_q       <= 1'b0;
            skip_out_q  <= 1'b0;
            t_near_q    <= '0;
            t_far_q     <= '0;
        end else begin
            valid_out_q <= valid_out_d;
            hit_q       <= hit_d;
            skip_out_q  <= skip_out_d;
            t_near_q    <= t_near_d;
            t_far_q     <= t_far_d;
        end
    end

    assign valid_out = valid_out_q;
    assign hit       = hit_q;
    assign skip_out  = skip_out_q;
    assign t_near    = t_near_q;
    assign t_far     = t_far_q;

endmodule
